// File: rtl/ram_axi_bridge_pkg.sv
// Shared definitions for the RAM-to-AXI bridge: response codes, FSM states,
// byte-lane constants and the transfer-size clamp.
package ram_axi_bridge_pkg;

    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_LEN_W  = 8;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Byte-lane index width and the byte-to-bit shift (lane * 8).
    localparam int LANE_IDX_W = 3;
    localparam int LANE_SHIFT = 3;

    localparam logic [2:0] SIZE_MAX = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW_W,
        ST_B
    } state_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [2:0]            size;
        logic [AXI_DATA_W-1:0] wdata;
    } req_t;

    // Sizes beyond a doubleword do not fit the 64-bit bus and collapse to it.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > SIZE_MAX) ? SIZE_MAX : size;
    endfunction

endpackage

// File: rtl/ram_axi_lane.sv
// Byte-lane steering shared by both directions: positions write data and
// strobes onto the bus, and extracts right-aligned, size-masked read data.
module ram_axi_lane
    import ram_axi_bridge_pkg::*;
(
    input  logic [LANE_IDX_W-1:0] i_lane,
    input  logic [2:0]            i_size,
    input  logic [AXI_DATA_W-1:0] i_wdata,
    input  logic [AXI_DATA_W-1:0] i_rdata,
    output logic [AXI_DATA_W-1:0] o_wdata,
    output logic [AXI_STRB_W-1:0] o_wstrb,
    output logic [AXI_DATA_W-1:0] o_rdata
);

    logic [LANE_IDX_W+LANE_SHIFT-1:0] w_shamt;
    logic [AXI_STRB_W-1:0]            w_byte_mask;
    logic [AXI_DATA_W-1:0]            w_data_mask;

    assign w_shamt = {i_lane, {LANE_SHIFT{1'b0}}};

    // NOTE: every output of this block gets a value on every path (the default
    // arm covers the rest), otherwise synthesis would infer latches.
    always_comb begin
        case (clamp_size(i_size))
            3'd0:    begin w_byte_mask = 8'h01; w_data_mask = 64'h0000_0000_0000_00FF; end
            3'd1:    begin w_byte_mask = 8'h03; w_data_mask = 64'h0000_0000_0000_FFFF; end
            3'd2:    begin w_byte_mask = 8'h0F; w_data_mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin w_byte_mask = 8'hFF; w_data_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
    end

    // Strobe shift drops lanes above the bus; misaligned accesses are undefined.
    assign o_wstrb = w_byte_mask << i_lane;
    assign o_wdata = i_wdata << w_shamt;
    assign o_rdata = (i_rdata >> w_shamt) & w_data_mask;

endmodule

// File: rtl/ram_axi_bridge.sv
// Single-outstanding bridge from a simple valid/ready RAM port to AXI4
// single-beat reads and writes.
module ram_axi_bridge
    import ram_axi_bridge_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_ram_valid,
    input  logic                  i_ram_wen,
    input  logic [AXI_ADDR_W-1:0] i_ram_addr,
    input  logic [AXI_DATA_W-1:0] i_ram_wdata,
    input  logic [2:0]            i_ram_size,
    output logic                  o_ram_ready,
    output logic [AXI_DATA_W-1:0] o_ram_rdata,
    output logic                  o_ram_err,

    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [AXI_ADDR_W-1:0] o_awaddr,
    output logic [2:0]            o_awsize,
    output logic [AXI_ID_W-1:0]   o_awid,
    output logic [AXI_LEN_W-1:0]  o_awlen,
    output logic [1:0]            o_awburst,

    output logic                  o_wvalid,
    input  logic                  i_wready,
    output logic [AXI_DATA_W-1:0] o_wdata,
    output logic [AXI_STRB_W-1:0] o_wstrb,
    output logic                  o_wlast,

    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,

    output logic                  o_arvalid,
    input  logic                  i_arready,
    output logic [AXI_ADDR_W-1:0] o_araddr,
    output logic [2:0]            o_arsize,
    output logic [AXI_ID_W-1:0]   o_arid,
    output logic [AXI_LEN_W-1:0]  o_arlen,
    output logic [1:0]            o_arburst,

    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [AXI_DATA_W-1:0] i_rdata,
    input  logic [1:0]            i_rresp
);

    state_t r_state;
    req_t   r_req;
    logic   r_aw_done;
    logic   r_w_done;

    state_t                w_state_nxt;
    logic                  w_capture;
    logic                  w_aw_done_nxt;
    logic                  w_w_done_nxt;
    logic [AXI_DATA_W-1:0] w_lane_rdata;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_req     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            if (w_capture) begin
                r_req.addr  <= i_ram_addr;
                r_req.size  <= clamp_size(i_ram_size);
                r_req.wdata <= i_ram_wdata;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        o_arvalid     = 1'b0;
        o_rready      = 1'b0;
        o_awvalid     = 1'b0;
        o_wvalid      = 1'b0;
        o_bready      = 1'b0;
        o_ram_ready   = 1'b0;
        o_ram_err     = 1'b0;
        o_ram_rdata   = '0;

        // Handshake outputs are held low for the whole reset cycle.
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_ram_valid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = i_ram_wen ? ST_AW_W : ST_AR;
                    end
                end
                ST_AR: begin
                    o_arvalid = 1'b1;
                    if (i_arready) w_state_nxt = ST_R;
                end
                ST_R: begin
                    o_rready = 1'b1;
                    if (i_rvalid) begin
                        o_ram_ready = 1'b1;
                        o_ram_rdata = w_lane_rdata;
                        o_ram_err   = (i_rresp != AXI_RESP_OKAY);
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_AW_W: begin
                    // AW and W complete independently; leave once both are done,
                    // whether in separate cycles or the same one.
                    o_awvalid     = !r_aw_done;
                    o_wvalid      = !r_w_done;
                    w_aw_done_nxt = r_aw_done | i_awready;
                    w_w_done_nxt  = r_w_done | i_wready;
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                        w_state_nxt   = ST_B;
                    end
                end
                ST_B: begin
                    o_bready = 1'b1;
                    if (i_bvalid) begin
                        o_ram_ready = 1'b1;
                        o_ram_err   = (i_bresp != AXI_RESP_OKAY);
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    ram_axi_lane u_lane (
        .i_lane  (r_req.addr[LANE_IDX_W-1:0]),
        .i_size  (r_req.size),
        .i_wdata (r_req.wdata),
        .i_rdata (i_rdata),
        .o_wdata (o_wdata),
        .o_wstrb (o_wstrb),
        .o_rdata (w_lane_rdata)
    );

    assign o_awaddr  = r_req.addr;
    assign o_araddr  = r_req.addr;
    assign o_awsize  = r_req.size;
    assign o_arsize  = r_req.size;

    // Single-beat transfers only.
    assign o_awid    = '0;
    assign o_arid    = '0;
    assign o_awlen   = '0;
    assign o_arlen   = '0;
    assign o_awburst = AXI_BURST_INCR;
    assign o_arburst = AXI_BURST_INCR;
    assign o_wlast   = 1'b1;

endmodule
